alu_sequencer: RTL

//  Initiator side of the 8-bit ALU interface: issues NBYTES-wide ADD/RSH/XOR/AND one byte
//  per cycle over the byte ALU ports (op, two operands, shift/carry in; result, shift/carry
//  out, zero). Chains carry/shift bits between bytes and assembles the wide result and flags.

---
 rtl/alu_sequencer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Drives a combinational 8-bit ALU one byte per cycle to run NBYTES-wide ADD/RSH/XOR/AND.
// Latency: NBYTES EXEC cycles, then the response is held until it is taken.
// Backpressure: req_ready only in IDLE; rsp_* stay stable while rsp_ready is low.
module alu_sequencer #(
    parameter int NBYTES = 2
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    input  logic                req_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_data,
    output logic                rsp_cout,
    output logic                rsp_zero,
    output logic                busy,
    output logic [2:0]          alu_op,
    output logic [7:0]          alu_a,
    output logic [7:0]          alu_b,
    output logic                alu_sc_in,
    input  logic [7:0]          alu_out,
    input  logic                alu_sc_out,
    input  logic                alu_zero
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES) + 1;

    // Only the chained ops are decoded here; every other code goes straight to the ALU.
    localparam logic [2:0] kADD = 3'd1;
    localparam logic [2:0] kRSH = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    result_q, result_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            carry_q, carry_d;
    logic            zacc_q, zacc_d;

    logic [IW-1:0]   byte_i;
    logic            last_byte;
    logic            op_chained;

    // Right shift walks MSB first so each shifted-out bit lands in the next lower byte.
    assign byte_i     = (op_q == kRSH) ? (IW'(NBYTES - 1) - idx_q) : idx_q;
    assign last_byte  = (idx_q == IW'(NBYTES - 1));
    assign op_chained = (op_q == kADD) || (op_q == kRSH);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            zacc_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            zacc_q   <= zacc_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        zacc_d   = zacc_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = EXEC;
                    op_d    = req_op;
                    a_d     = req_a;
                    b_d     = req_b;
                    idx_d   = '0;
                    zacc_d  = 1'b1;
                    carry_d = ((req_op == kADD) || (req_op == kRSH)) ? req_cin : 1'b0;
                end
            end
            EXEC: begin
                for (int k = 0; k < NBYTES; k++) begin
                    if (byte_i == IW'(k)) begin
                        result_d[8*k +: 8] = alu_out;
                    end
                end
                carry_d = alu_sc_out;
                zacc_d  = zacc_q & alu_zero;
                idx_d   = idx_q + 1'b1;
                if (last_byte) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        rsp_data  = '0;
        rsp_cout  = 1'b0;
        rsp_zero  = 1'b0;
        busy      = 1'b0;
        alu_op    = 3'd0;
        alu_a     = 8'd0;
        alu_b     = 8'd0;
        alu_sc_in = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = ~Reset;
            end
            EXEC: begin
                busy      = 1'b1;
                alu_op    = op_q;
                alu_sc_in = carry_q;
                for (int k = 0; k < NBYTES; k++) begin
                    if (byte_i == IW'(k)) begin
                        alu_a = a_q[8*k +: 8];
                        alu_b = b_q[8*k +: 8];
                    end
                end
            end
            DONE: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                rsp_data  = result_q;
                rsp_cout  = op_chained ? carry_q : 1'b0;
                rsp_zero  = zacc_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
